fifo_uart_drain: RTL

Downstream stage for the 4-bit FIFO. It pulls one nibble at a time from the FIFO read port and transmits it on a single UART line, 8N1 and LSB first, one character per FIFO entry. It uses one clock domain and has no flow control beyond the FIFO `empty` flag.

---
 rtl/fifo_uart_drain_if.sv | 30 +++
 rtl/fifo_uart_drain.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fifo_uart_drain_if.sv
// ============================================================================
// Module      : fifo_uart_drain_if
// Description : Read-port bundle between a 4-bit FIFO and its UART drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface fifo_uart_drain_if #(
    parameter int DATA_W = 4
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;

    // master: the reader (drain); slave: the FIFO itself
    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en
    );
endinterface

`default_nettype wire

// File: rtl/fifo_uart_drain.sv
// ============================================================================
// Module      : fifo_uart_drain
// Description : Pops FIFO nibbles one at a time and sends each as an 8N1
//               UART character, LSB first. Define FIFO_UART_ASCII_HEX_EN to
//               send the nibble as its uppercase ASCII hex digit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_uart_drain #(
    parameter int CLK_DIV = 868,
    parameter int DATA_W  = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fifo_uart_drain_if.master  fifo,
    output logic               tx,
    output logic               busy
);

    localparam logic [15:0] C_BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [2:0]  C_BIT_LAST  = 3'd7;

`ifdef FIFO_UART_ASCII_HEX_EN
    if (DATA_W != 4) begin : g_bad_data_w
        $error("fifo_uart_drain: DATA_W must be 4 in ASCII hex mode");
    end
`else
    if (DATA_W < 1 || DATA_W > 8) begin : g_bad_data_w
        $error("fifo_uart_drain: DATA_W must be 1..8");
    end
`endif

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("fifo_uart_drain: CLK_DIV must be 2..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q,  baud_d;
    logic [2:0]  bit_q,   bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q,    tx_d;
    logic        busy_q,  busy_d;
    logic        w_bit_end;

    function automatic logic [7:0] encode(input logic [DATA_W-1:0] d);
`ifdef FIFO_UART_ASCII_HEX_EN
        return (d < 4'd10) ? (8'h30 + 8'(d)) : (8'h37 + 8'(d));
`else
        return 8'(d);
`endif
    endfunction

    assign w_bit_end       = (baud_q == C_BAUD_LAST);
    assign fifo.fifo_rd_en = (state_q == S_REQ);
    assign tx              = tx_q;
    assign busy            = busy_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo.fifo_empty) begin
                    state_d = S_REQ;
                    busy_d  = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // read data is valid now, one cycle after the strobe
                shreg_d = encode(fifo.fifo_rd_data);
                state_d = S_START;
                tx_d    = 1'b0;
                baud_d  = 16'd0;
            end
            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    baud_d = 16'd0;
                    if (bit_q == C_BIT_LAST) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    state_d = S_IDLE;
                    baud_d  = 16'd0;
                    busy_d  = 1'b0;
                end else begin
                    baud_d  = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

endmodule

`default_nettype wire
